// File: rtl/sequence_generator_fsm.sv
// Serial pattern generator: shifts a captured pattern out MSB first,
// repeated back to back a requested number of times, then pulses done.
// Optional build macro: SEQ_GEN_PARITY_EN appends an even-parity bit
// after every repetition of the pattern.
module sequence_generator_fsm #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic [CNT_W-1:0]     repeat_i,
  output logic                 out_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int IDX_W = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef SEQ_GEN_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [PATTERN_W-1:0] pattern_reg, pattern_next;
  logic [CNT_W-1:0]     rep_reg, rep_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 out_reg, out_next;
  logic                 valid_reg, valid_next;
  logic                 done_reg, done_next;

  // The repetition counter holds the number of repetitions still to send,
  // including the one currently on the wire.
  logic last_rep;
  assign last_rep = (rep_reg <= CNT_W'(1));

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      rep_reg     <= '0;
      idx_reg     <= IDX_MSB;
      out_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pattern_reg <= pattern_next;
      rep_reg     <= rep_next;
      idx_reg     <= idx_next;
      out_reg     <= out_next;
      valid_reg   <= valid_next;
      done_reg    <= done_next;
    end
  end

  // Next state and next output values; outputs are computed one cycle ahead
  // so that they leave the block straight from flops.
  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    rep_next     = rep_reg;
    idx_next     = idx_reg;
    out_next     = 1'b0;
    valid_next   = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next   = SHIFT;
          pattern_next = pattern_i;
          rep_next     = (repeat_i == '0) ? CNT_W'(1) : repeat_i;
          idx_next     = IDX_MSB;
          out_next     = pattern_i[PATTERN_W-1];
          valid_next   = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_reg != '0) begin
          idx_next   = idx_reg - IDX_W'(1);
          out_next   = pattern_reg[idx_next];
          valid_next = 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_next = PARITY;
          out_next   = ^pattern_reg;
          valid_next = 1'b1;
`else
          if (!last_rep) begin
            rep_next   = rep_reg - CNT_W'(1);
            idx_next   = IDX_MSB;
            out_next   = pattern_reg[PATTERN_W-1];
            valid_next = 1'b1;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: begin
        if (!last_rep) begin
          state_next = SHIFT;
          rep_next   = rep_reg - CNT_W'(1);
          idx_next   = IDX_MSB;
          out_next   = pattern_reg[PATTERN_W-1];
          valid_next = 1'b1;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_o   = out_reg;
  assign valid_o = valid_reg;
  assign done_o  = done_reg;
  assign busy_o  = (state_reg != IDLE);

endmodule

// File: tb/tb_sequence_generator_fsm.sv
// Directed bench for sequence_generator_fsm (default build, PATTERN_W=4).
module tb_sequence_generator_fsm;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] pattern_i = 4'h0;
  logic [3:0] repeat_i = 4'h0;
  logic       out_o, valid_o, busy_o, done_o;

  int n_checks = 0;
  int n_fail = 0;

  sequence_generator_fsm #(.PATTERN_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i),
    .pattern_i(pattern_i), .repeat_i(repeat_i),
    .out_o(out_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pattern;
    logic [3:0]  rep;
    int          len;
    logic [15:0] bits;   // expected stream, first bit at bits[len-1]
  } vec_t;

  vec_t vecs[6];

  // Compares {out, valid, busy, done} against the expected nibble.
  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {out_o, valid_o, busy_o, done_o};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {out,valid,busy,done} got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge idle.
  task automatic run_vector(input vec_t v, output int hits, output int last_hit);
    logic [3:0] sr;
    sr = 4'h0;
    hits = 0;
    last_hit = -1;
    start_i = 1'b1;
    pattern_i = v.pattern;
    repeat_i = v.rep;
    @(negedge clk);
    start_i = 1'b0;
    pattern_i = ~v.pattern;
    repeat_i = 4'hF;
    for (int i = 0; i < v.len; i++) begin
      chk("bit", {v.bits[v.len-1-i], 3'b110});
      if (valid_o) begin
        sr = {sr[2:0], out_o};
        if (sr == 4'b1011) begin
          hits++;
          last_hit = i;
        end
      end
      @(negedge clk);
    end
    chk("done_cycle", 4'b0011);
    @(negedge clk);
    chk("idle_after", 4'b0000);
  endtask

  initial begin
    int hits, last_hit;
    vecs[0] = '{pattern: 4'b1011, rep: 4'd1, len: 4,  bits: 16'h000B};
    vecs[1] = '{pattern: 4'b1011, rep: 4'd2, len: 8,  bits: 16'h00BB};
    vecs[2] = '{pattern: 4'b1011, rep: 4'd0, len: 4,  bits: 16'h000B};
    vecs[3] = '{pattern: 4'b0110, rep: 4'd3, len: 12, bits: 16'h0666};
    vecs[4] = '{pattern: 4'b1000, rep: 4'd1, len: 4,  bits: 16'h0008};
    vecs[5] = '{pattern: 4'b0001, rep: 4'd2, len: 8,  bits: 16'h0011};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", 4'b0000);
    reset_i = 1'b0;
    @(negedge clk);
    chk("idle_no_start", 4'b0000);

    // Table-driven transmissions
    for (int k = 0; k < 6; k++) begin
      run_vector(vecs[k], hits, last_hit);
      $display("vector %0d pattern=%b repeat=%0d bits=%0d detections=%0d",
               k, vecs[k].pattern, vecs[k].rep, vecs[k].len, hits);
      if (k == 0) begin
        chk_int("loopback_hits", hits, 1);
        chk_int("loopback_align", last_hit, 3);
      end
    end

    // Held start, pattern changed mid-run: no effect, restart after one IDLE
    start_i = 1'b1; pattern_i = 4'b1011; repeat_i = 4'd1;
    @(negedge clk); chk("hold_c1", 4'b1110);
    @(negedge clk); chk("hold_c2", 4'b0110); pattern_i = 4'b0000;
    @(negedge clk); chk("hold_c3", 4'b1110);
    @(negedge clk); chk("hold_c4", 4'b1110);
    @(negedge clk); chk("hold_done", 4'b0011);
    @(negedge clk); chk("hold_gap", 4'b0000);
    @(negedge clk); chk("hold_restart", 4'b0110); start_i = 1'b0;
    repeat (3) begin @(negedge clk); chk("hold_zero_bits", 4'b0110); end
    @(negedge clk); chk("hold_done2", 4'b0011);
    @(negedge clk); chk("hold_idle", 4'b0000);
    $display("held-start sequence complete");

    // Reset mid-transmission aborts without a done pulse
    start_i = 1'b1; pattern_i = 4'b1011; repeat_i = 4'd1;
    @(negedge clk); chk("rst_c1", 4'b1110); start_i = 1'b0;
    @(negedge clk); chk("rst_c2", 4'b0110); reset_i = 1'b1;
    @(negedge clk); chk("rst_c3", 4'b0000); reset_i = 1'b0;
    @(negedge clk); chk("rst_c4", 4'b0000); start_i = 1'b1;
    @(negedge clk); chk("rst_restart", 4'b1110); start_i = 1'b0;
    @(negedge clk); chk("rst_b1", 4'b0110);
    @(negedge clk); chk("rst_b2", 4'b1110);
    @(negedge clk); chk("rst_b3", 4'b1110);
    @(negedge clk); chk("rst_done", 4'b0011);
    @(negedge clk); chk("rst_idle", 4'b0000);
    $display("mid-run reset sequence complete");

    // Reset wins over simultaneous start; first start after it is accepted
    reset_i = 1'b1; start_i = 1'b1; pattern_i = 4'b1011;
    @(negedge clk); chk("prio_reset", 4'b0000); reset_i = 1'b0;
    @(negedge clk); chk("prio_first_start", 4'b1110); start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("prio_idle", 4'b0000);
    $display("reset priority sequence complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_generator_fsm.md
SEQUENCE_GENERATOR_FSM -- requirements
Module: sequence_generator_fsm

Interface
REQ-001 Parameter PATTERN_W, default 4: number of bits per pattern, minimum 2.
REQ-002 Parameter CNT_W, default 4: width of the repetition count.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_i, input, 1: reset, synchronous and active-high.
REQ-005 Port start_i, input, 1: request to begin a transmission; sampled only in IDLE.
REQ-006 Port pattern_i, input, PATTERN_W: bit pattern to transmit, MSB first; captured on accepted start.
REQ-007 Port repeat_i, input, CNT_W: number of back-to-back pattern repetitions; captured on accepted start.
REQ-008 Port out_o, output, 1: serial data bit, registered.
REQ-009 Port valid_o, output, 1: out_o carries a transmitted bit this cycle.
REQ-010 Port busy_o, output, 1: high in every state except IDLE.
REQ-011 Port done_o, output, 1: single-cycle pulse after the final bit.

Function
REQ-012 States SHALL be IDLE, SHIFT, PARITY (only with the macro in REQ-029) and DONE.
REQ-013 IDLE with start_i=1 at edge k SHALL capture pattern_i and repeat_i and enter SHIFT; the first bit (pattern MSB) SHALL be on out_o with valid_o=1 in cycle k+1.
REQ-014 SHIFT SHALL present one bit per cycle, MSB to LSB, each held exactly one cycle with valid_o=1 and no idle gaps.
REQ-015 Bit index SHALL count PATTERN_W-1 down to 0. After bit 0 it SHALL wrap to PATTERN_W-1 and the repetition counter SHALL decrement, if repetitions remain.
REQ-016 repeat_i=0 SHALL be treated as 1. Total data bits SHALL be PATTERN_W*max(repeat_i,1).
REQ-017 After the last bit of the last repetition the FSM SHALL enter DONE for exactly one cycle: done_o=1, valid_o=0, out_o=0, busy_o=1. It SHALL then return to IDLE.
REQ-018 In IDLE and DONE, out_o=0 and valid_o=0.
REQ-019 start_i SHALL be ignored in SHIFT, PARITY and DONE. Changes on pattern_i and repeat_i during a transmission SHALL NOT affect it.
REQ-020 start_i=1 held continuously SHALL start a new transmission on the first IDLE cycle after DONE. Minimum gap between transmissions is one IDLE cycle.
REQ-021 Output bit order SHALL be directly consumable by the team's serial sequence detector (in_i <= out_o) with no reordering.

Reset
REQ-022 reset_i=1 at a rising edge SHALL force IDLE, regardless of current state.
REQ-023 Reset values: out_o=0, valid_o=0, busy_o=0, done_o=0, bit index=PATTERN_W-1, repetition counter=0, captured pattern=0.
REQ-024 Reset mid-transmission SHALL abort it with no done_o pulse.
REQ-025 reset_i SHALL take priority over a simultaneous start_i.
REQ-026 The first start_i with reset_i=0 after reset SHALL be accepted normally.
REQ-027 Outputs SHALL be undefined-free (no X) from the first edge with reset_i=1.
REQ-028 Before the first reset edge, outputs are don't-care.

Configuration
REQ-029 Macro SEQ_GEN_PARITY_EN defined: after each repetition's bit 0, the FSM SHALL enter PARITY for one cycle. In PARITY it SHALL drive out_o = XOR of the captured pattern (even parity) with valid_o=1, then go to SHIFT for the next repetition or to DONE.
REQ-030 Macro undefined: the PARITY state and its logic SHALL NOT exist. Bit 0 of a repetition is followed directly by the next MSB or by DONE.

Verification
REQ-031 PATTERN_W=4, pattern_i=4'b1011, repeat_i=1, start at edge 0 -> out_o 1,0,1,1 with valid_o=1 in cycles 1-4; done_o=1 in cycle 5; busy_o=0 in cycle 6.
REQ-032 pattern_i=4'b1011, repeat_i=2 -> out_o 1,0,1,1,1,0,1,1 in cycles 1-8 contiguous; done_o in cycle 9; repeat_i=0 -> identical to repeat_i=1.
REQ-033 SEQ_GEN_PARITY_EN defined, pattern_i=4'b1011, repeat_i=1 -> out_o 1,0,1,1,1 in cycles 1-5; done_o in cycle 6. Same with pattern_i=4'b1001 -> parity bit 0.
REQ-034 start_i=1 and pattern_i changed to 4'b0000 in cycle 2 of a 4'b1011 run -> stream unchanged, no restart; held start_i restarts on the first IDLE cycle after done_o.
REQ-035 reset_i=1 at edge 2 of a 4'b1011 run -> from cycle 3, out_o=0, valid_o=0, busy_o=0, no done_o; start at edge 4 -> MSB in cycle 5.
REQ-036 Loopback out_o into the sequence detector's in_i with pattern 4'b1011, repeat_i=1 -> detector detected_o asserts once, aligned to the final transmitted bit.
